// File: rtl/alu_op_issuer.sv
// alu_op_issuer: issue stage and result collector for the 4-bit 3-phase ALU.
//   Buffers tagged commands, presents one operand set per ALU frame (held for
//   the whole frame), samples the ALU's registered result/flags one frame later
//   and returns {result, flags, tag} over a valid/ready response port.
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready        command handshake; cmd_ready is registered
//   cmd_a, cmd_b, cmd_op       operands and op (00 add, 01 sub, 10 and, 11 or)
//   cmd_tag                    returned unchanged with the result
//   alu_a, alu_b, alu_op       registered operands to the ALU
//   alu_result, alu_carry,
//   alu_zero, alu_overflow     registered outputs from the ALU
//   rsp_valid/rsp_ready        response handshake
//   rsp_result, rsp_flags,
//   rsp_tag                    head response; flags = {carry, zero, overflow}
//   frame_phase                0=IDLE, 1=EXEC, 2=WB, mirrors the ALU FSM
module alu_op_issuer #(
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned RSP_DEPTH = 4,
  parameter int unsigned TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic [1:0]       cmd_op,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [1:0]       alu_op,
  input  logic [3:0]       alu_result,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_result,
  output logic [2:0]       rsp_flags,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [1:0]       frame_phase
);

  localparam int unsigned CmdPtrW = $clog2(CMD_DEPTH);
  localparam int unsigned RspPtrW = $clog2(RSP_DEPTH);
  localparam int unsigned CmdCntW = CmdPtrW + 1;
  localparam int unsigned RspCntW = RspPtrW + 1;
  localparam int unsigned RspSumW = RspCntW + 1;
  localparam int unsigned CmdW    = 10 + TAG_W;
  localparam int unsigned RspW    = 7 + TAG_W;

  localparam logic [CmdCntW-1:0] CmdFull  = CmdCntW'(CMD_DEPTH);
  localparam logic [RspSumW-1:0] RspLimit = RspSumW'(RSP_DEPTH);

  typedef enum logic [1:0] {PhIdle = 2'd0, PhExec = 2'd1, PhWb = 2'd2} phase_e;

  phase_e phase_q, phase_d;

  logic [CmdW-1:0]    cmd_mem_q [CMD_DEPTH];
  logic [CmdPtrW-1:0] cmd_wptr_q, cmd_rptr_q;
  logic [CmdCntW-1:0] cmd_cnt_q, cmd_cnt_d;
  logic               cmd_ready_q;
  logic               cmd_push, cmd_pop;
  logic [CmdW-1:0]    cmd_head;

  logic [RspW-1:0]    rsp_mem_q [RSP_DEPTH];
  logic [RspPtrW-1:0] rsp_wptr_q, rsp_rptr_q;
  logic [RspCntW-1:0] rsp_cnt_q, rsp_cnt_d;
  logic               rsp_push, rsp_pop;
  logic [RspW-1:0]    rsp_head;

  logic               exec_valid_q, collect_valid_q;
  logic [TAG_W-1:0]   exec_tag_q, collect_tag_q;
  logic [RspSumW-1:0] credit_use;
  logic               issue;

  logic [3:0]         alu_a_q, alu_b_q;
  logic [1:0]         alu_op_q;

  // Free-running phase counter; the illegal encoding falls back to IDLE.
  always_comb begin
    phase_d = PhIdle;
    case (phase_q)
      PhIdle:  phase_d = PhExec;
      PhExec:  phase_d = PhWb;
      default: phase_d = PhIdle;
    endcase
  end

  assign cmd_head = cmd_mem_q[cmd_rptr_q];
  assign rsp_head = rsp_mem_q[rsp_rptr_q];

  assign rsp_valid = (rsp_cnt_q != '0);
  assign rsp_pop   = rsp_valid && rsp_ready;

  // cmd_ready_q mirrors "not full" for the current count, so a full FIFO
  // refuses a push even on an edge where it is also popped.
  assign cmd_push = cmd_valid && cmd_ready_q;

  // Credits: buffered responses (after this edge's pop) plus results still in
  // the pipe must leave room for the command being issued.
  always_comb begin
    credit_use = RspSumW'(rsp_cnt_q) - RspSumW'(rsp_pop)
               + RspSumW'(exec_valid_q) + RspSumW'(collect_valid_q);
  end

  assign issue   = (phase_q == PhWb) && (cmd_cnt_q != '0) && (credit_use < RspLimit);
  assign cmd_pop = issue;

  // The collect slot holds the result of the frame that just ended; the ALU
  // output is stable through the following IDLE phase.
  assign rsp_push = (phase_q == PhIdle) && collect_valid_q;

  assign cmd_cnt_d = cmd_cnt_q + CmdCntW'(cmd_push) - CmdCntW'(cmd_pop);
  assign rsp_cnt_d = rsp_cnt_q + RspCntW'(rsp_push) - RspCntW'(rsp_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q         <= PhIdle;
      cmd_wptr_q      <= '0;
      cmd_rptr_q      <= '0;
      cmd_cnt_q       <= '0;
      cmd_ready_q     <= 1'b0;
      rsp_wptr_q      <= '0;
      rsp_rptr_q      <= '0;
      rsp_cnt_q       <= '0;
      exec_valid_q    <= 1'b0;
      exec_tag_q      <= '0;
      collect_valid_q <= 1'b0;
      collect_tag_q   <= '0;
      alu_a_q         <= '0;
      alu_b_q         <= '0;
      alu_op_q        <= '0;
    end else begin
      phase_q     <= phase_d;
      cmd_cnt_q   <= cmd_cnt_d;
      cmd_ready_q <= (cmd_cnt_d != CmdFull);
      rsp_cnt_q   <= rsp_cnt_d;
      if (cmd_push) cmd_wptr_q <= cmd_wptr_q + CmdPtrW'(1);
      if (cmd_pop)  cmd_rptr_q <= cmd_rptr_q + CmdPtrW'(1);
      if (rsp_push) rsp_wptr_q <= rsp_wptr_q + RspPtrW'(1);
      if (rsp_pop)  rsp_rptr_q <= rsp_rptr_q + RspPtrW'(1);

      if (phase_q == PhWb) begin
        exec_valid_q    <= issue;
        collect_valid_q <= exec_valid_q;
        collect_tag_q   <= exec_tag_q;
        if (issue) begin
          exec_tag_q <= cmd_head[TAG_W-1:0];
          alu_a_q    <= cmd_head[CmdW-1 -: 4];
          alu_b_q    <= cmd_head[CmdW-5 -: 4];
          alu_op_q   <= cmd_head[TAG_W+1 -: 2];
        end
      end else if (rsp_push) begin
        collect_valid_q <= 1'b0;
      end
    end
  end

  // Storage arrays carry no reset; pointers and counts define their contents.
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem_q[cmd_wptr_q] <= {cmd_a, cmd_b, cmd_op, cmd_tag};
    if (rsp_push) begin
      rsp_mem_q[rsp_wptr_q] <= {alu_result, alu_carry, alu_zero, alu_overflow, collect_tag_q};
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign rsp_result  = rsp_head[RspW-1 -: 4];
  assign rsp_flags   = rsp_head[TAG_W+2 -: 3];
  assign rsp_tag     = rsp_head[TAG_W-1:0];
  assign frame_phase = phase_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// tb_alu_op_issuer: bench for alu_op_issuer with a stub 3-phase ALU, a
// scoreboard of expected responses and directed plus randomized stimulus.
module tb_alu_op_issuer;

  localparam int unsigned TagW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [3:0]      cmd_a = '0;
  logic [3:0]      cmd_b = '0;
  logic [1:0]      cmd_op = '0;
  logic [TagW-1:0] cmd_tag = '0;
  logic [3:0]      alu_a, alu_b;
  logic [1:0]      alu_op;
  logic [3:0]      alu_result;
  logic            alu_carry, alu_zero, alu_overflow;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [3:0]      rsp_result;
  logic [2:0]      rsp_flags;
  logic [TagW-1:0] rsp_tag;
  logic [1:0]      frame_phase;

  alu_op_issuer #(
    .CMD_DEPTH(4),
    .RSP_DEPTH(4),
    .TAG_W    (TagW)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_op      (cmd_op),
    .cmd_tag     (cmd_tag),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .alu_carry   (alu_carry),
    .alu_zero    (alu_zero),
    .alu_overflow(alu_overflow),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_flags   (rsp_flags),
    .rsp_tag     (rsp_tag),
    .frame_phase (frame_phase)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;       // edges since reset release; frame phase is cyc % 3
  int pop_count = 0;

  logic [10:0] exp_q[$];
  logic [10:0] pop_dat[$];
  int          pop_cyc[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference ALU behaviour: {result[3:0], carry, zero, overflow}.
  // Sub reports borrow in carry.
  function automatic logic [6:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] op);
    int ua, ub, sa, sb, r, s;
    logic c, v;
    logic [3:0] res;
    ua = int'(a);
    ub = int'(b);
    sa = a[3] ? ua - 16 : ua;
    sb = b[3] ? ub - 16 : ub;
    c = 1'b0;
    v = 1'b0;
    case (op)
      2'd0: begin r = ua + ub; s = sa + sb; c = (r > 15); v = (s > 7) || (s < -8); end
      2'd1: begin r = ua - ub; s = sa - sb; c = (ua < ub); v = (s > 7) || (s < -8); end
      2'd2: r = ua & ub;
      default: r = ua | ub;
    endcase
    res = r[3:0];
    return {res, c, (res == 4'd0), v};
  endfunction

  // Stub ALU: own IDLE->EXEC->WB counter, result registered at the end of WB.
  logic [1:0] alu_ph;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_ph <= 2'd0;
      {alu_result, alu_carry, alu_zero, alu_overflow} <= '0;
    end else begin
      if (alu_ph == 2'd2) {alu_result, alu_carry, alu_zero, alu_overflow} <= alu_fn(alu_a, alu_b, alu_op);
      alu_ph <= (alu_ph == 2'd2) ? 2'd0 : 2'(alu_ph + 2'd1);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Monitor on the falling edge: handshakes seen here complete on the next rise.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("phase", 32'(frame_phase), 32'(cyc % 3));
      if (cmd_valid && cmd_ready) exp_q.push_back({alu_fn(cmd_a, cmd_b, cmd_op), cmd_tag});
      if (rsp_valid && rsp_ready) begin
        pop_count++;
        pop_dat.push_back({rsp_result, rsp_flags, rsp_tag});
        pop_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          chk("rsp_data", 32'({rsp_result, rsp_flags, rsp_tag}), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                      input logic [3:0] tag, output int acc_cyc);
    bit ok;
    ok = 1'b0;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
    cmd_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    acc_cyc = cyc;
    chk("send_accepted", 32'(ok), 32'd1);
  endtask

  // Smallest edge after acc with pre-edge phase WB.
  function automatic int next_issue(input int acc);
    int e;
    e = acc + 1;
    while (e % 3 != 0) e++;
    return e;
  endfunction

  task automatic wait_pops(input int n);
    for (int i = 0; i < 300 && pop_cyc.size() < n; i++) tick(1);
    chk("pops_seen", 32'(pop_cyc.size()), 32'(n));
  endtask

  task automatic drain(input string tag);
    rsp_ready = 1'b1;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick(1);
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  int acc, acc2, e, t, c, refused, pc;
  bit hs, seen;

  initial begin
    // 1: reset release with no commands
    tick(3);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_alu_a", 32'(alu_a), 32'd0);
    chk("t1_alu_b", 32'(alu_b), 32'd0);
    chk("t1_alu_op", 32'(alu_op), 32'd0);
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("t1_cmd_ready", 32'(cmd_ready), 32'd1);
    tick(6);
    chk("t1_rsp_idle", 32'(rsp_valid), 32'd0);

    // 2: F + 1 -> 0 with carry and zero, latency issue+4
    send(4'hF, 4'h1, 2'd0, 4'd3, acc);
    e = next_issue(acc);
    seen = 1'b0;
    t = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        t = cyc;
        break;
      end
    end
    chk("t2_seen", 32'(seen), 32'd1);
    chk("t2_latency", 32'(t), 32'(e + 4));
    chk("t2_result", 32'(rsp_result), 32'h0);
    chk("t2_flags", 32'(rsp_flags), 32'b110);
    chk("t2_tag", 32'(rsp_tag), 32'd3);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    tick(1);
    rsp_ready = 1'b0;

    // 3: back-to-back commands, issues 3 cycles apart
    pop_dat.delete();
    pop_cyc.delete();
    rsp_ready = 1'b1;
    send(4'h7, 4'h1, 2'd0, 4'd1, acc);
    send(4'h3, 4'h5, 2'd1, 4'd2, acc2);
    e = next_issue(acc);
    wait_pops(2);
    chk("t3_first_latency", 32'(pop_cyc[0]), 32'(e + 4));
    chk("t3_spacing", 32'(pop_cyc[1] - pop_cyc[0]), 32'd3);
    chk("t3_rsp0", 32'(pop_dat[0]), 32'({4'h8, 3'b001, 4'h1}));
    chk("t3_rsp1", 32'(pop_dat[1]), 32'({4'hE, 3'b100, 4'h2}));
    rsp_ready = 1'b0;
    tick(2);

    // 4: response back-pressure with 8 and/or commands
    pc = pop_count;
    for (int i = 0; i < 8; i++) begin
      send(4'($urandom), 4'($urandom), 2'(2 + (i % 2)), 4'(i + 4), acc);
    end
    tick(15);
    chk("t4_cmd_ready_low", 32'(cmd_ready), 32'd0);
    chk("t4_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t4_no_pop", 32'(pop_count - pc), 32'd0);

    // 6: offer while full; freeing a credit lets an issue pop the full FIFO,
    // but the offered command is only taken on the following edge
    cmd_a = 4'hA; cmd_b = 4'h5; cmd_op = 2'd3; cmd_tag = 4'hC;
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    refused = 0;
    c = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        c = cyc;
        break;
      end
      refused++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    acc = cyc;
    chk("t6_refused", 32'(refused > 0), 32'd1);
    chk("t6_ready_after_issue", 32'(c % 3), 32'd0);
    chk("t6_accept_edge", 32'(acc), 32'(c + 1));
    drain("t4_drain");
    chk("t4_all_returned", 32'(pop_count - pc), 32'd9);
    rsp_ready = 1'b0;

    // 5: reset during phase 1 with work in flight
    send(4'h2, 4'h3, 2'd0, 4'd7, acc);
    send(4'h9, 4'h1, 2'd1, 4'd8, acc2);
    tick(5);
    while (cyc % 3 != 1) tick(1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t5_alu_a", 32'(alu_a), 32'd0);
    chk("t5_alu_b", 32'(alu_b), 32'd0);
    chk("t5_alu_op", 32'(alu_op), 32'd0);
    chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_phase", 32'(frame_phase), 32'd0);
    tick(2);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    pc = pop_count;
    tick(20);
    chk("t5_no_stale", 32'(pop_count - pc), 32'd0);

    // Randomized traffic against the scoreboard
    cmd_valid = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      hs = cmd_valid && cmd_ready;
      @(posedge clk); #1;
      if (hs || !cmd_valid) begin
        cmd_valid = ($urandom_range(9) < 7);
        cmd_a     = 4'($urandom);
        cmd_b     = 4'($urandom);
        cmd_op    = 2'($urandom);
        cmd_tag   = 4'($urandom);
      end
      rsp_ready = ($urandom_range(9) < 6);
    end
    cmd_valid = 1'b0;
    drain("rand_drain");
    tick(10);
    chk("final_rsp_idle", 32'(rsp_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
